fpga_obi_ext_responder: RTL



---
 rtl/fpga_obi_ext_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fpga_obi_ext_responder.sv
// fpga_obi_ext_responder: OBI target for the x_heep external
// peripheral port with scratch RAM, grant stall and debug status.
module fpga_obi_ext_responder #(
  parameter int unsigned NUM_WORDS = 64,
  parameter int unsigned GNT_WAIT  = 0,
  parameter logic [31:0] ERR_RDATA = 32'hBADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [15:0] acc_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned HI_LO = IDX_W + 2;
  localparam logic [3:0] WAIT_LD =
    4'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
  localparam logic [IDX_W:0] NW_C = (IDX_W + 1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              gnt;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [15:0]       acc_q;
  logic              unused_addr;

  logic [31:0] mem [0:NUM_WORDS-1];

  assign idx = addr_i[IDX_W+1:2];
  assign in_range = (addr_i[15:HI_LO] == '0)
                 && ({1'b0, idx} < NW_C);
  assign rd_word = in_range ? mem[idx] : ERR_RDATA;

  // Grant is suppressed while reset is held.
  assign gnt_o  = gnt & rst_ni;
  assign accept = req_i & gnt_o;

  assign rvalid_o  = (state_q == RESP);
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign acc_cnt_o = acc_q;

  assign unused_addr = ^{addr_i[31:16], addr_i[1:0]};

  // State and grant-wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait countdown and grant generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (GNT_WAIT == 0) begin
          gnt = req_i;
          if (req_i) state_d = RESP;
        end else if (req_i) begin
          state_d = WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      WAIT: begin
        gnt = (cnt_q == 4'd0);
        if (!req_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (!req_i) begin
          state_d = IDLE;
        end else if (GNT_WAIT == 0) begin
          gnt     = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte-masked scratch write on an in-range write accept.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Response data, sticky error and saturating accept count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else if (accept) begin
      rdata_q <= we_i ? 32'd0 : rd_word;
      if (!in_range) err_q <= 1'b1;
      if (acc_q != 16'hFFFF) acc_q <= acc_q + 16'd1;
    end
  end

endmodule
